ysyx_22040895_ifetch: RTL and testbench

//  Multi-cycle instruction fetch stage, upstream of the IDU; replaces the single-cycle inst_i/instaddr_o path.
//  - Owns the PC and issues one 32-bit fetch at a time over a valid/ready request / valid response imem port.
//  - Buffers returned {pc, inst, fault} in a small FIFO and presents them to the IDU with valid/ready.
//  - Applies redirects (branch, jump, trap dnpc from the EXU) and discards stale responses.

---
 rtl/ysyx_22040895_ifetch_pkg.sv | 30 +++
 rtl/ysyx_22040895_ifetch_fifo.sv | 67 ++++++
 rtl/ysyx_22040895_ifetch.sv | 179 +++++++++++++++++
 tb/tb_ysyx_22040895_ifetch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ysyx_22040895_ifetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), used as filler for faulting fetches.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_t;

  // One buffered fetch result as handed to the decoder.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Clear the two low address bits so the fetch address is word aligned.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'd3;
  endfunction

endpackage

// File: rtl/ysyx_22040895_ifetch_fifo.sv
// Instruction buffer between fetch and decode: clear/push/pop with occupancy count.
// Latency: registered, an entry is visible the cycle after its push.
// Backpressure: producer must not push when full (guaranteed by the fetch credit check).
module ysyx_22040895_ifetch_fifo
  import ysyx_22040895_ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [ENTRY_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [ENTRY_W-1:0] last_head;
  logic               do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // When empty the outputs keep showing whatever was presented last.
  assign head_data  = head_valid ? mem[rd_ptr] : last_head;

  // Storage, pointers and occupancy; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      last_head <= head_data;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/ysyx_22040895_ifetch.sv
// Multi-cycle fetch: owns the PC, one outstanding imem request, buffers results for the IDU.
// Latency: 2 cycles request-to-inst_valid_o with a zero-wait imem; at most 1 inst per 2 cycles.
// Backpressure: no request is issued unless the buffer has room for its response (credit).
// Optional build macro YSYX_22040895_IFETCH_MISALIGN_EN: misaligned redirect targets
// produce a fault entry instead of being silently word aligned.
module ysyx_22040895_ifetch
  import ysyx_22040895_ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_inst_i,
  input  logic        imem_rsp_err_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        fault_o,
  input  logic        inst_ready_i
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);

  fetch_state_t state, state_nxt;
  logic [63:0]  pc, pc_nxt;
  logic [63:0]  req_pc, req_pc_nxt;
  logic [63:0]  hold_addr, hold_addr_nxt;
  logic         hold, hold_nxt;
  logic         mis_pend, mis_pend_nxt;
  logic         parked, parked_nxt;

  logic [63:0]  target;
  logic         target_misaligned;
  logic [CW-1:0] count;
  logic         credit_ok;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic         req_fire;
  logic         push;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic         head_valid;

`ifdef YSYX_22040895_IFETCH_MISALIGN_EN
  assign target            = redirect_pc_i;
  assign target_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
  assign target            = word_align(redirect_pc_i);
  assign target_misaligned = 1'b0;
`endif

  // count + 1 <= FIFO_DEPTH: reserve a slot for the response before asking for it.
  assign credit_ok = (count < DEPTH_CNT);

  // A request already shown to the bus stays up (same address) until accepted,
  // regardless of redirects or state; otherwise only REQ may start a new one.
  assign req_valid = hold || ((state == S_REQ) && credit_ok && !mis_pend && !parked);
  assign req_addr  = hold ? hold_addr : pc;
  assign req_fire  = req_valid && imem_req_ready_i;

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = req_addr;

  // Next-state, PC, push and request-hold decisions; redirect overrides everything.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_pc_nxt    = req_pc;
    hold_nxt      = hold;
    hold_addr_nxt = hold_addr;
    mis_pend_nxt  = mis_pend;
    parked_nxt    = parked;
    push          = 1'b0;
    push_entry    = '0;

    if (req_fire) begin
      hold_nxt = 1'b0;
    end else if (req_valid) begin
      hold_nxt      = 1'b1;
      hold_addr_nxt = req_addr;
    end

    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          req_pc_nxt = pc;
          state_nxt  = S_WAIT;
        end else if (mis_pend && !hold && credit_ok) begin
          // Misaligned target: report it in-band and stop fetching.
          push         = 1'b1;
          push_entry   = '{pc: pc, inst: NOP_INST, fault: 1'b1};
          mis_pend_nxt = 1'b0;
          parked_nxt   = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          push       = 1'b1;
          push_entry = '{pc:    req_pc,
                         inst:  imem_rsp_err_i ? NOP_INST : imem_rsp_inst_i,
                         fault: imem_rsp_err_i};
          pc_nxt     = req_pc + 64'd4;
          state_nxt  = S_REQ;
        end
      end
      S_FLUSH: begin
        if (imem_rsp_valid_i) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (redirect_i) begin
      push         = 1'b0;
      pc_nxt       = target;
      mis_pend_nxt = target_misaligned;
      parked_nxt   = 1'b0;
      case (state)
        S_IDLE:  state_nxt = S_REQ;
        // Anything already on the bus will return a response that must be dropped.
        S_REQ:   state_nxt = req_valid ? S_FLUSH : S_REQ;
        S_WAIT,
        S_FLUSH: state_nxt = imem_rsp_valid_i ? S_REQ : S_FLUSH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM and PC state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      req_pc    <= '0;
      hold      <= 1'b0;
      hold_addr <= '0;
      mis_pend  <= 1'b0;
      parked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      req_pc    <= req_pc_nxt;
      hold      <= hold_nxt;
      hold_addr <= hold_addr_nxt;
      mis_pend  <= mis_pend_nxt;
      parked    <= parked_nxt;
    end
  end

  ysyx_22040895_ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_i),
    .push       (push),
    .push_data  (push_entry),
    .pop        (inst_ready_i),
    .head_valid (head_valid),
    .head_data  (head_entry),
    .count      (count)
  );

  assign inst_valid_o = head_valid;
  assign inst_o       = head_entry.inst;
  assign pc_o         = head_entry.pc;
  assign fault_o      = head_entry.fault;

endmodule

// File: tb/tb_ysyx_22040895_ifetch.sv
// Directed bench for the fetch stage with a small imem responder driven from the stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_ysyx_22040895_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic [63:0] imem_req_addr_o;
  logic        imem_req_ready_i = 1'b1;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_inst_i = '0;
  logic        imem_rsp_err_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        fault_o;
  logic        inst_ready_i = 1'b1;

  int          tests = 0;
  int          fails = 0;

  // imem responder state
  logic        pend = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          rsp_lat = 0;
  logic [63:0] err_addr = '1;

  ysyx_22040895_ifetch dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_inst_i  (imem_rsp_inst_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .fault_o          (fault_o),
    .inst_ready_i     (inst_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // imem contents: address xor a fixed pattern
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: note a handshake, cross the edge, then drive the response for the new cycle.
  task automatic tick();
    #1;
    if (imem_req_valid_o && imem_req_ready_i) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr_o;
      pend_cnt  = rsp_lat;
    end
    @(posedge clk);
    #1;
    if (pend && pend_cnt == 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_inst_i  = imem_word(pend_addr);
      imem_rsp_err_i   = (pend_addr == err_addr);
      pend             = 1'b0;
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_err_i   = 1'b0;
      if (pend) pend_cnt--;
    end
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    redirect_i       = 1'b0;
    pend             = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_req_valid", imem_req_valid_o, 0);
    chk("rst_inst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_fault", fault_o, 0);

    // 1: zero-wait imem, IDU always ready
    do_reset();
    tick();
    chk("t1_req0_valid", imem_req_valid_o, 1);
    chk("t1_req0_addr", imem_req_addr_o, 64'h8000_0000);
    chk("t1_c1_inst_valid", inst_valid_o, 0);
    tick();
    chk("t1_wait_req_valid", imem_req_valid_o, 0);
    tick();
    chk("t1_c3_inst_valid", inst_valid_o, 1);
    chk("t1_c3_pc", pc_o, 64'h8000_0000);
    chk("t1_c3_inst", inst_o, 32'h8F0F_0000);
    chk("t1_c3_fault", fault_o, 0);
    chk("t1_req1_addr", imem_req_addr_o, 64'h8000_0004);
    tick();
    chk("t1_c4_inst_valid", inst_valid_o, 0);
    tick();
    chk("t1_c5_pc", pc_o, 64'h8000_0004);
    chk("t1_c5_inst", inst_o, 32'h8F0F_0004);
    chk("t1_req2_addr", imem_req_addr_o, 64'h8000_0008);
    tick();
    tick();
    chk("t1_c7_pc", pc_o, 64'h8000_0008);
    chk("t1_c7_inst", inst_o, 32'h8F0F_0008);

    // 2: IDU stalled -> buffer fills to depth, no more requests, then in-order drain
    inst_ready_i = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("t2_full_req_valid", imem_req_valid_o, 0);
    chk("t2_full_inst_valid", inst_valid_o, 1);
    chk("t2_full_pc", pc_o, 64'h8000_0000);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2_stall_req_valid", imem_req_valid_o, 0);
    end
    chk("t2_stall_head_pc", pc_o, 64'h8000_0000);
    inst_ready_i = 1'b1;
    tick();
    chk("t2_drain1_pc", pc_o, 64'h8000_0004);
    chk("t2_drain1_inst", inst_o, 32'h8F0F_0004);
    chk("t2_drain1_req_addr", imem_req_addr_o, 64'h8000_0008);
    chk("t2_drain1_req_valid", imem_req_valid_o, 1);
    tick();
    chk("t2_empty_inst_valid", inst_valid_o, 0);
    tick();
    chk("t2_next_valid", inst_valid_o, 1);
    chk("t2_next_pc", pc_o, 64'h8000_0008);

    // 3: redirect while waiting on a slow response
    rsp_lat = 2;
    do_reset();
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h8000_0100;
    tick();
    redirect_i = 1'b0;
    chk("t3_flush_req_valid", imem_req_valid_o, 0);
    chk("t3_flush_inst_valid", inst_valid_o, 0);
    tick();
    chk("t3_flush2_req_valid", imem_req_valid_o, 0);
    tick();
    chk("t3_drop_inst_valid", inst_valid_o, 0);
    chk("t3_target_req_valid", imem_req_valid_o, 1);
    chk("t3_target_req_addr", imem_req_addr_o, 64'h8000_0100);
    rsp_lat = 0;
    tick();
    chk("t3_no_stale", inst_valid_o, 0);
    tick();
    chk("t3_tgt_valid", inst_valid_o, 1);
    chk("t3_tgt_pc", pc_o, 64'h8000_0100);
    chk("t3_tgt_inst", inst_o, 32'h8F0F_0100);

    // 4: redirect while a request is stuck waiting for imem ready
    imem_req_ready_i = 1'b0;
    do_reset();
    tick();
    chk("t4_req_valid", imem_req_valid_o, 1);
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h8000_0100;
    tick();
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_held_valid", imem_req_valid_o, 1);
      chk("t4_held_addr", imem_req_addr_o, 64'h8000_0000);
      if (i < 2) tick();
    end
    imem_req_ready_i = 1'b1;
    tick();
    chk("t4_accepted_req_valid", imem_req_valid_o, 0);
    tick();
    chk("t4_target_req_addr", imem_req_addr_o, 64'h8000_0100);
    chk("t4_target_req_valid", imem_req_valid_o, 1);
    chk("t4_drop_inst_valid", inst_valid_o, 0);
    tick();
    chk("t4_no_stale", inst_valid_o, 0);
    tick();
    chk("t4_tgt_valid", inst_valid_o, 1);
    chk("t4_tgt_pc", pc_o, 64'h8000_0100);
    chk("t4_tgt_inst", inst_o, 32'h8F0F_0100);

    // 5: access fault at 8000_0008
    err_addr = 64'h8000_0008;
    do_reset();
    repeat (5) tick();
    chk("t5_prev_fault", fault_o, 0);
    tick();
    tick();
    chk("t5_fault_valid", inst_valid_o, 1);
    chk("t5_fault_pc", pc_o, 64'h8000_0008);
    chk("t5_fault", fault_o, 1);
    chk("t5_fault_inst", inst_o, 32'h0000_0013);
    chk("t5_next_addr", imem_req_addr_o, 64'h8000_000C);
    chk("t5_next_req_valid", imem_req_valid_o, 1);
    err_addr = '1;

    // 6: misaligned redirect target
    do_reset();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h8000_0102;
    tick();
    redirect_i = 1'b0;
    tick();
`ifdef YSYX_22040895_IFETCH_MISALIGN_EN
    chk("t6_no_req", imem_req_valid_o, 0);
    tick();
    chk("t6_mis_valid", inst_valid_o, 1);
    chk("t6_mis_pc", pc_o, 64'h8000_0102);
    chk("t6_mis_fault", fault_o, 1);
    chk("t6_mis_inst", inst_o, 32'h0000_0013);
    chk("t6_parked_req", imem_req_valid_o, 0);
    tick();
    tick();
    chk("t6_still_parked", imem_req_valid_o, 0);
    redirect_i    = 1'b1;
    redirect_pc_i = 64'h8000_0200;
    tick();
    redirect_i = 1'b0;
    chk("t6_resume_valid", imem_req_valid_o, 1);
    chk("t6_resume_addr", imem_req_addr_o, 64'h8000_0200);
`else
    chk("t6_aligned_req_valid", imem_req_valid_o, 1);
    chk("t6_aligned_req_addr", imem_req_addr_o, 64'h8000_0100);
    tick();
    chk("t6_wait_inst_valid", inst_valid_o, 0);
    tick();
    chk("t6_aligned_valid", inst_valid_o, 1);
    chk("t6_aligned_pc", pc_o, 64'h8000_0100);
    chk("t6_aligned_fault", fault_o, 0);
    chk("t6_aligned_inst", inst_o, 32'h8F0F_0100);
`endif

    // 7: PC increment wraps modulo 2^64
    do_reset();
    redirect_i    = 1'b1;
    redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("t7_top_addr", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    chk("t7_top_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t7_top_inst", inst_o, 32'hF0F0_FFFC);
    chk("t7_wrap_addr", imem_req_addr_o, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
